demux_scheduler: RTL and testbench



---
 rtl/demux_scheduler.sv | 80 ++++++++
 tb/tb_demux_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/demux_scheduler.sv
// demux_scheduler: round-robin 1-to-8 channel scheduler with one-word buffer and stall timeout
module demux_scheduler #(
  parameter int DW = 8,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [7:0]    en_mask,
  output logic [DW-1:0] out_data,
  output logic [2:0]    out_sel,
  output logic [7:0]    out_valid,
  input  logic [7:0]    out_ready,
  output logic [7:0]    skip_cnt,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;
  state_t state, state_d;
  logic [DW-1:0] data_d;
  logic [2:0] ptr, ptr_d, sel_d, gnt;
  logic [7:0] wait_cnt, wait_d, skip_d;
  assign in_ready = rst_n && state == IDLE && |en_mask;
  assign out_valid = state == SEND ? 8'd1 << out_sel : 8'd0;
  assign busy = state != IDLE;
  always_comb begin
    gnt = ptr;
    for (int i = 7; i >= 0; i--)
      gnt = en_mask[ptr + 3'(i)] ? ptr + 3'(i) : gnt;
  end
  always_comb begin
    state_d = state;
    data_d = out_data;
    ptr_d = ptr;
    sel_d = out_sel;
    wait_d = wait_cnt;
    skip_d = skip_cnt;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        data_d = in_data;
        state_d = ARB;
      end
      ARB: if (|en_mask) begin
        sel_d = gnt;
        wait_d = '0;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready[out_sel]) begin
          ptr_d = out_sel + 3'd1;
          state_d = IDLE;
        end else if (!en_mask[out_sel] || wait_cnt == 8'(TIMEOUT - 1)) begin
          ptr_d = out_sel + 3'd1;
          state_d = ARB;
          skip_d = en_mask[out_sel] && skip_cnt != 8'hff ? skip_cnt + 8'd1 : skip_cnt;
        end else
          wait_d = wait_cnt + 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      out_data <= '0;
      ptr <= '0;
      out_sel <= '0;
      wait_cnt <= '0;
      skip_cnt <= '0;
    end else begin
      state <= state_d;
      out_data <= data_d;
      ptr <= ptr_d;
      out_sel <= sel_d;
      wait_cnt <= wait_d;
      skip_cnt <= skip_d;
    end
  end
endmodule

// File: tb/tb_demux_scheduler.sv
// tb_demux_scheduler: directed and random checks of demux_scheduler against a behavioural model
module tb_demux_scheduler;
  localparam int TO = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, busy;
  logic [7:0] in_data = 0, en_mask = 0, out_ready = 0, out_data, out_valid, skip_cnt;
  logic [2:0] out_sel;
  int n_chk = 0, n_err = 0;
  bit m_have = 0, m_send = 0, m_acc = 0;
  logic [7:0] m_word = 0;
  int m_ptr = 0, m_sel = 0, m_age = 0, m_skip = 0;
  int obs_ch[$];
  logic [7:0] obs_d[$];
  demux_scheduler #(.DW(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .en_mask(en_mask), .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .skip_cnt(skip_cnt), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_step();
    m_acc = 0;
    if (!rst_n) begin
      m_have = 0; m_send = 0; m_word = 0; m_ptr = 0; m_sel = 0; m_age = 0; m_skip = 0;
    end else if (!m_have) begin
      if (in_valid && en_mask != 0) begin
        m_have = 1; m_word = in_data; m_acc = 1;
      end
    end else if (!m_send) begin
      for (int k = 0; k < 8; k++)
        if (en_mask[(m_ptr + k) % 8]) begin
          m_sel = (m_ptr + k) % 8; m_send = 1; m_age = 0;
          break;
        end
    end else if (out_ready[m_sel]) begin
      m_have = 0; m_send = 0; m_ptr = (m_sel + 1) % 8;
    end else if (!en_mask[m_sel]) begin
      m_send = 0; m_ptr = (m_sel + 1) % 8;
    end else if (m_age == TO - 1) begin
      m_send = 0; m_ptr = (m_sel + 1) % 8;
      if (m_skip < 255) m_skip++;
    end else
      m_age++;
  endtask
  task automatic cycle();
    #1;
    check("out_valid", out_valid, m_send ? 32'd1 << m_sel : 32'd0);
    check("in_ready", in_ready, rst_n && !m_have && en_mask != 0);
    check("busy", busy, m_have);
    check("out_sel", out_sel, m_sel);
    check("out_data", out_data, m_word);
    check("skip_cnt", skip_cnt, m_skip);
    if (rst_n && (out_valid & out_ready) != 0) begin
      obs_ch.push_back(out_sel);
      obs_d.push_back(out_data);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic send_word(input logic [7:0] d);
    int n = 0;
    in_data = d;
    in_valid = 1;
    do begin cycle(); n++; end while (!m_acc && n < 40);
    in_valid = 0;
    n = 0;
    while (m_have && n < 100) begin cycle(); n++; end
    check("drain", m_have, 0);
  endtask
  initial begin
    @(posedge clk);
    @(negedge clk);
    cycle();
    rst_n = 1;
    en_mask = 8'hff;
    out_ready = 8'hff;
    for (int i = 0; i < 8; i++) begin
      send_word(8'(8'h11 * (i + 1)));
      check("rot_ch", obs_ch[$], i);
      check("rot_data", obs_d[$], 8'(8'h11 * (i + 1)));
    end
    check("rot_skip", skip_cnt, 0);
    obs_ch.delete(); obs_d.delete();
    en_mask = 8'h24;
    for (int i = 0; i < 4; i++) send_word(8'(8'h30 + i));
    check("sparse_n", obs_ch.size(), 4);
    for (int i = 0; i < 4; i++) check("sparse_ch", obs_ch[i], (i % 2 == 0) ? 2 : 5);
    obs_ch.delete(); obs_d.delete();
    en_mask = 8'h03;
    out_ready = 8'h02;
    send_word(8'ha5);
    check("to_n", obs_ch.size(), 1);
    check("to_ch", obs_ch[0], 1);
    check("to_data", obs_d[0], 8'ha5);
    check("to_skip", skip_cnt, 1);
    obs_ch.delete(); obs_d.delete();
    out_ready = 8'h00;
    in_data = 8'h3c;
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    repeat (3) cycle();
    out_ready = 8'h01;
    cycle();
    check("hs_to_n", obs_ch.size(), 1);
    check("hs_to_ch", obs_ch[0], 0);
    check("hs_to_data", obs_d[0], 8'h3c);
    check("hs_to_skip", skip_cnt, 1);
    obs_ch.delete(); obs_d.delete();
    out_ready = 8'hff;
    en_mask = 8'h00;
    in_valid = 1;
    in_data = 8'h5c;
    repeat (3) begin
      #1 check("mask0_in_ready", in_ready, 0);
      cycle();
    end
    en_mask = 8'hff;
    cycle();
    en_mask = 8'h00;
    in_valid = 0;
    repeat (10) cycle();
    en_mask = 8'h10;
    for (int n = 0; n < 20 && m_have; n++) cycle();
    check("hold_n", obs_ch.size(), 1);
    check("hold_ch", obs_ch[0], 4);
    check("hold_data", obs_d[0], 8'h5c);
    obs_ch.delete(); obs_d.delete();
    en_mask = 8'h08;
    out_ready = 8'h00;
    in_data = 8'h99;
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    #1 check("pre_rst_valid", out_valid, 8'h08);
    rst_n = 0;
    cycle();
    rst_n = 1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_skip", skip_cnt, 0);
    en_mask = 8'hff;
    out_ready = 8'hff;
    send_word(8'h77);
    check("post_rst_ch", obs_ch[$], 0);
    check("post_rst_data", obs_d[$], 8'h77);
    for (int i = 0; i < 600; i++) begin
      en_mask = ($urandom % 4 == 0) ? 8'h00 : 8'($urandom);
      out_ready = 8'($urandom & $urandom);
      in_valid = 1'($urandom);
      in_data = 8'($urandom);
      rst_n = ($urandom % 64) != 0;
      cycle();
    end
    rst_n = 1;
    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
